bram_sdp: RTL and testbench

- Single-clock simple-dual-port block RAM: one write port and one read port sharing `clk`.
- Modelled on the 7-series 18Kb/36Kb SDP primitive.
- Used as the storage element of `shift_reg`-style delay lines and other buffers: the address counter drives both ports, and with read-before-write the block yields the data written exactly DEPTH cycles earlier.

---
 rtl/bram_sdp_pkg.sv | 54 +++++
 rtl/bram_sdp_outreg.sv | 28 ++
 rtl/bram_sdp.sv | 101 ++++++++++
 tb/tb_bram_sdp.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bram_sdp_pkg.sv
// Purpose : shared constants and geometry helpers for the bram_sdp block RAM.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Helpers derive depth, address width and write-enable width from the
// primitive size and data width, matching the 7-series SDP aspect ratios.
package bram_sdp_pkg;

  localparam int LANE_W = 9;

  localparam string SIZE_18K         = "18Kb";
  localparam string SIZE_36K         = "36Kb";
  localparam string DEVICE_7SERIES   = "7SERIES";
  localparam string MODE_READ_FIRST  = "READ_FIRST";
  localparam string MODE_WRITE_FIRST = "WRITE_FIRST";

  // Depth for an 18Kb primitive. A 36Kb primitive doubles it, except that
  // the 37..72 bit widths only exist on 36Kb and stay at 512 entries.
  function automatic int calc_depth(input bit is_36k, input int width);
    int d;
    if (width <= 1)       d = 16384;
    else if (width <= 2)  d = 8192;
    else if (width <= 4)  d = 4096;
    else if (width <= 9)  d = 2048;
    else if (width <= 18) d = 1024;
    else                  d = 512;
    if (is_36k && width <= 36) d = d * 2;
    return d;
  endfunction

  function automatic int calc_addr_width(input bit is_36k, input int width);
    return $clog2(calc_depth(is_36k, width));
  endfunction

  function automatic int calc_we_width(input int width);
    if (width <= 9)       return 1;
    else if (width <= 18) return 2;
    else if (width <= 36) return 4;
    else                  return 8;
  endfunction

  function automatic bit cfg_legal(input bit is_18k, input bit is_36k,
                                   input bit dev_ok, input bit mode_ok,
                                   input int do_reg, input int rd_w,
                                   input int wr_w);
    bit ok;
    ok = (is_18k || is_36k) && dev_ok && mode_ok;
    ok = ok && (do_reg == 0 || do_reg == 1);
    ok = ok && (rd_w == wr_w) && (rd_w >= 1);
    ok = ok && (rd_w <= (is_36k ? 72 : 36));
    return ok;
  endfunction

endpackage

// File: rtl/bram_sdp_outreg.sv
// Purpose : optional output pipeline register of the SDP RAM.
// Latency : 1 cycle (loads every edge, no enable).
// Backpr. : none; free-running register.
//
// Ports: clk, rst (sync, active-high -> SRVAL), d (latch value), q (data out).
module bram_sdp_outreg
  import bram_sdp_pkg::*;
#(
  parameter int                W     = 36,
  parameter logic [W-1:0]      SRVAL = '0,
  parameter logic [W-1:0]      INIT  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg = INIT;

  always_ff @(posedge clk) begin
    if (rst) q_reg <= SRVAL;
    else     q_reg <= d;
  end

  assign q = q_reg;

endmodule

// File: rtl/bram_sdp.sv
// Purpose : single-clock simple-dual-port block RAM (7-series SDP model).
// Latency : 1 cycle read (DO_REG=0) or 2 cycles (DO_REG=1).
// Backpr. : none; rden=0 holds the read latch, writes always accepted.
//
// Ports: clk; rst (sync, active-high, output stages only); wraddr/di/we/wren
// write port with 9-bit lane enables; rdaddr/rden read port; data_o read data.
module bram_sdp
  import bram_sdp_pkg::*;
#(
  parameter string                   BRAM_SIZE   = "18Kb",
  parameter string                   DEVICE      = "7SERIES",
  parameter int                      DO_REG      = 0,
  parameter int                      READ_WIDTH  = 36,
  parameter int                      WRITE_WIDTH = 36,
  parameter string                   WRITE_MODE  = "READ_FIRST",
  parameter logic [READ_WIDTH-1:0]   SRVAL       = '0,
  parameter logic [READ_WIDTH-1:0]   INIT        = '0,
  localparam bit                     IS_36K      = (BRAM_SIZE == SIZE_36K),
  localparam int                     DEPTH       = calc_depth(IS_36K, READ_WIDTH),
  localparam int                     ADDR_WIDTH  = calc_addr_width(IS_36K, READ_WIDTH),
  localparam int                     WE_WIDTH    = calc_we_width(READ_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  wraddr,
  input  logic [ADDR_WIDTH-1:0]  rdaddr,
  input  logic [WRITE_WIDTH-1:0] di,
  input  logic [WE_WIDTH-1:0]    we,
  input  logic                   wren,
  input  logic                   rden,
  output logic [READ_WIDTH-1:0]  data_o
);

  localparam bit IS_18K      = (BRAM_SIZE == SIZE_18K);
  localparam bit DEV_OK      = (DEVICE == DEVICE_7SERIES);
  localparam bit WRITE_FIRST = (WRITE_MODE == MODE_WRITE_FIRST);
  localparam bit MODE_OK     = WRITE_FIRST || (WRITE_MODE == MODE_READ_FIRST);
  localparam bit CFG_OK      = cfg_legal(IS_18K, IS_36K, DEV_OK, MODE_OK,
                                         DO_REG, READ_WIDTH, WRITE_WIDTH);

  if (!CFG_OK) begin : g_bad_cfg
    $error("bram_sdp: illegal BRAM_SIZE/DEVICE/width/WRITE_MODE/DO_REG combination");
  end

  logic [READ_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [READ_WIDTH-1:0] rd_latch    = INIT;

  logic [READ_WIDTH-1:0] lane_mask;
  logic [READ_WIDTH-1:0] rd_word;
  logic [READ_WIDTH-1:0] merged_word;
  logic                  collide;
  logic                  unused_we;

  // Expand per-lane enables to a per-bit mask. Lanes past the data width
  // have no bits, so their enables fall away here.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < READ_WIDTH; b++) begin
      lane_mask[b] = we[b / LANE_W];
    end
  end

  assign unused_we = ^we;

  assign rd_word     = mem[rdaddr];
  assign merged_word = (rd_word & ~lane_mask) | (di & lane_mask);
  assign collide     = wren && (rdaddr == wraddr);

  // Writes ignore rst: reset only touches the output path.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[wraddr] <= (mem[wraddr] & ~lane_mask) | (di & lane_mask);
    end
  end

  // READ_FIRST falls out naturally from sampling the array before the write
  // lands; WRITE_FIRST forwards the enabled lanes of di on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_latch <= SRVAL;
    end else if (rden) begin
      rd_latch <= (WRITE_FIRST && collide) ? merged_word : rd_word;
    end
  end

  if (DO_REG == 1) begin : g_outreg
    bram_sdp_outreg #(
      .W     (READ_WIDTH),
      .SRVAL (SRVAL),
      .INIT  (INIT)
    ) u_outreg (
      .clk (clk),
      .rst (rst),
      .d   (rd_latch),
      .q   (data_o)
    );
  end else begin : g_no_outreg
    assign data_o = rd_latch;
  end

endmodule

// File: tb/tb_bram_sdp.sv
module tb_bram_sdp;

  logic        clk;
  logic        rst;
  logic [8:0]  wraddr;
  logic [8:0]  rdaddr;
  logic [24:0] di;
  logic [3:0]  we;
  logic        wren;
  logic        rden;

  logic [24:0] rf0_do;
  logic [24:0] rf1_do;
  logic [24:0] wf_do;
  logic [17:0] w18_do;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // READ_FIRST, 1-cycle latency
  bram_sdp #(.READ_WIDTH(25), .WRITE_WIDTH(25), .DO_REG(0),
             .WRITE_MODE("READ_FIRST"), .SRVAL(25'h155)) u_rf0 (
    .clk(clk), .rst(rst), .wraddr(wraddr), .rdaddr(rdaddr), .di(di),
    .we(we), .wren(wren), .rden(rden), .data_o(rf0_do));

  // READ_FIRST, 2-cycle latency
  bram_sdp #(.READ_WIDTH(25), .WRITE_WIDTH(25), .DO_REG(1),
             .WRITE_MODE("READ_FIRST"), .SRVAL(25'h155)) u_rf1 (
    .clk(clk), .rst(rst), .wraddr(wraddr), .rdaddr(rdaddr), .di(di),
    .we(we), .wren(wren), .rden(rden), .data_o(rf1_do));

  // WRITE_FIRST, 1-cycle latency
  bram_sdp #(.READ_WIDTH(25), .WRITE_WIDTH(25), .DO_REG(0),
             .WRITE_MODE("WRITE_FIRST")) u_wf (
    .clk(clk), .rst(rst), .wraddr(wraddr), .rdaddr(rdaddr), .di(di),
    .we(we), .wren(wren), .rden(rden), .data_o(wf_do));

  // 18-bit wide, two lanes, 1024 deep
  bram_sdp #(.READ_WIDTH(18), .WRITE_WIDTH(18), .DO_REG(0)) u_w18 (
    .clk(clk), .rst(rst), .wraddr({1'b0, wraddr}), .rdaddr({1'b0, rdaddr}),
    .di(di[17:0]), .we(we[1:0]), .wren(wren), .rden(rden), .data_o(w18_do));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [24:0] d, input logic [3:0] m);
    wraddr = a; di = d; we = m; wren = 1'b1; rden = 1'b0;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a);
    rdaddr = a; rden = 1'b1; wren = 1'b0;
    tick();
    rden = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wren = 1'b0; rden = 1'b0;
    wraddr = '0; rdaddr = '0; di = '0; we = '0;
    #1;

    // time-zero output is INIT (0)
    check("init_rf0", {7'b0, rf0_do}, 32'h0);
    check("init_rf1", {7'b0, rf1_do}, 32'h0);
    check("init_w18", {14'b0, w18_do}, 32'h0);

    rst = 1'b1;
    tick();
    check("rst_rf0", {7'b0, rf0_do}, 32'h155);
    check("rst_rf1", {7'b0, rf1_do}, 32'h155);
    check("rst_wf",  {7'b0, wf_do},  32'h0);
    rst = 1'b0;

    // delay line: both ports driven by the same wrapping counter
    for (int c = 0; c < 640; c++) begin
      wraddr = c[8:0]; rdaddr = c[8:0]; di = c[24:0];
      we = 4'hF; wren = 1'b1; rden = 1'b1;
      tick();
      check($sformatf("dly_rf0_c%0d", c), {7'b0, rf0_do},
            (c < 512) ? 32'd0 : 32'(c - 512));
      if (c == 0)
        check("dly_rf1_c0", {7'b0, rf1_do}, 32'h155);
      else
        check($sformatf("dly_rf1_c%0d", c), {7'b0, rf1_do},
              (c - 1 < 512) ? 32'd0 : 32'(c - 513));
      check($sformatf("dly_wf_c%0d", c), {7'b0, wf_do}, 32'(c));
    end
    wren = 1'b0; rden = 1'b0;

    // basic read and pipelined latency
    wr(9'd5, 25'h1ABCDEF, 4'hF);
    rd(9'd5);
    check("basic_rf0", {7'b0, rf0_do}, 32'h1ABCDEF);
    check("pipe_rf1_hold", {7'b0, rf1_do}, 32'd127);
    tick();
    check("pipe_rf1", {7'b0, rf1_do}, 32'h1ABCDEF);
    check("rden0_hold_rf0", {7'b0, rf0_do}, 32'h1ABCDEF);

    // same-address collisions
    wr(9'd3, 25'h0000AA, 4'hF);
    wraddr = 9'd3; rdaddr = 9'd3; di = 25'h000055; we = 4'hF;
    wren = 1'b1; rden = 1'b1;
    tick();
    wren = 1'b0; rden = 1'b0;
    check("coll_read_first", {7'b0, rf0_do}, 32'hAA);
    check("coll_write_first", {7'b0, wf_do}, 32'h55);
    rd(9'd3);
    check("coll_after_rf0", {7'b0, rf0_do}, 32'h55);

    // write-first with only lane 1 enabled: old data on the other lanes
    wraddr = 9'd3; rdaddr = 9'd3; di = 25'h1FFFFFF; we = 4'b0010;
    wren = 1'b1; rden = 1'b1;
    tick();
    wren = 1'b0; rden = 1'b0;
    check("coll_wf_lane", {7'b0, wf_do}, 32'h3FE55);
    check("coll_rf_lane", {7'b0, rf0_do}, 32'h55);

    // lane enables
    wr(9'd7, 25'h3FFFF, 4'hF);
    wr(9'd7, 25'h0, 4'b0001);
    rd(9'd7);
    check("lane_w18", {14'b0, w18_do}, 32'h3FE00);
    check("lane_rf0", {7'b0, rf0_do}, 32'h3FE00);

    // reset mid-stream, with a write landing during reset
    rdaddr = 9'd5; rden = 1'b1;
    tick();
    check("pre_rst_rf0", {7'b0, rf0_do}, 32'h1ABCDEF);
    rst = 1'b1;
    wraddr = 9'd9; di = 25'h123; we = 4'hF; wren = 1'b1;
    tick();
    wren = 1'b0;
    check("mid_rst1_rf0", {7'b0, rf0_do}, 32'h155);
    check("mid_rst1_rf1", {7'b0, rf1_do}, 32'h155);
    tick();
    check("mid_rst2_rf0", {7'b0, rf0_do}, 32'h155);
    check("mid_rst2_rf1", {7'b0, rf1_do}, 32'h155);
    rst = 1'b0;
    tick();
    check("post_rst_rf0", {7'b0, rf0_do}, 32'h1ABCDEF);
    check("post_rst_rf1_lag", {7'b0, rf1_do}, 32'h155);
    tick();
    check("post_rst_rf1", {7'b0, rf1_do}, 32'h1ABCDEF);
    rden = 1'b0;
    rd(9'd9);
    check("wr_during_rst", {7'b0, rf0_do}, 32'h123);
    rdaddr = 9'd5;
    tick();
    check("rden0_hold_end", {7'b0, rf0_do}, 32'h123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
